ahb_lite_master: RTL



---
 rtl/ahb_pkg.sv | 22 ++
 rtl/ahb_burst_addr_gen.sv | 31 +++
 rtl/ahb_lite_master.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// AHB-Lite encodings and master FSM state type.
// No logic: constants and typedefs only.
// Imported by ahb_lite_master and ahb_burst_addr_gen.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;

   localparam logic [2:0] HSIZE_WORD    = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_LAST
   } mst_state_t;

endpackage

// File: rtl/ahb_burst_addr_gen.sv
// Burst address register: loads a word-aligned start address, steps by 4.
// Latency: address updates on the edge after load/advance.
// Backpressure: advance is only asserted when the address phase is accepted.
// Ports: HCLK/HRESET, load + load_addr, advance, addr (current HADDR),
//        next_cross (the following beat starts a new 1 KB page).
module ahb_burst_addr_gen
   import ahb_pkg::*;
(
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        load,
   input  logic [31:0] load_addr,
   input  logic        advance,
   output logic [31:0] addr,
   output logic        next_cross
);

   always_ff @(posedge HCLK or negedge HRESET) begin
      if (!HRESET) begin
         addr <= '0;
      end else if (load) begin
         addr <= load_addr & ~32'h3;
      end else if (advance) begin
         addr <= addr + 32'd4;
      end
   end

   // Next address has [9:0] == 0 exactly when the current word is the last of its page.
   assign next_cross = (addr[9:2] == 8'hFF);

endmodule

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns (addr, dir, len) commands into word SINGLE/INCR bursts.
// Latency: accept at cycle 0, NONSEQ at 1, data phase at 2, done at 3 (no waits).
// Backpressure: cmd_ready only in IDLE; HREADY low freezes address and data phases.
// Ports: cmd_* command in, wr_data/wr_ready write beats, rd_data/rd_valid read beats,
//        done/err completion, H* AHB-Lite master signals.
// Optional: define AHB_LITE_MASTER_HRESP_EN to add HRESP and error termination;
//        otherwise err is always 0.
module ahb_lite_master
   import ahb_pkg::*;
#(
   parameter int MAX_BEATS = 16,
   parameter int LEN_W     = 5
) (
   input  logic             HCLK,
   input  logic             HRESET,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_write,
   input  logic [31:0]      cmd_addr,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic [31:0]      wr_data,
   output logic             wr_ready,
   output logic [31:0]      rd_data,
   output logic             rd_valid,
   output logic             done,
   output logic             err,
   output logic [31:0]      HADDR,
   output logic [1:0]       HTRANS,
   output logic             HWRITE,
   output logic [2:0]       HSIZE,
   output logic [2:0]       HBURST,
   output logic [31:0]      HWDATA,
   input  logic [31:0]      HRDATA,
`ifdef AHB_LITE_MASTER_HRESP_EN
   input  logic             HRESP,
`endif
   input  logic             HREADY
);

   mst_state_t       state;
   logic [LEN_W-1:0] len_n;
   logic [LEN_W-1:0] addr_left;
   logic [LEN_W-1:0] data_left;
   logic             dphase;     // a data phase is outstanding on the bus
   logic             err_flag;   // current command hit an ERROR response
   logic             accept;
   logic             addr_acc;
   logic             advance;
   logic             next_cross;
   logic             data_done;
   logic             last_data;
   logic             err_hit;

   always_comb begin
      len_n = cmd_len;
      if (cmd_len == '0)
         len_n = LEN_W'(1);
      else if (cmd_len > LEN_W'(MAX_BEATS))
         len_n = LEN_W'(MAX_BEATS);
   end

   assign cmd_ready = (state == ST_IDLE);
   assign accept    = cmd_valid & cmd_ready;
   assign addr_acc  = HTRANS[1] & HREADY;
   assign advance   = addr_acc & (addr_left != LEN_W'(1));
   assign wr_ready  = addr_acc & HWRITE;
   assign data_done = dphase & HREADY;
   // An errored command finishes on its second ERROR cycle regardless of beats left.
   assign last_data = data_done & ((data_left == LEN_W'(1)) | err_flag);
   assign HSIZE     = HSIZE_WORD;

`ifdef AHB_LITE_MASTER_HRESP_EN
   // First ERROR cycle: HRESP high while the data phase is still stalled.
   assign err_hit = dphase & HRESP & ~HREADY;
`else
   assign err_hit = 1'b0;
`endif

   ahb_burst_addr_gen u_addr_gen (
      .HCLK       (HCLK),
      .HRESET     (HRESET),
      .load       (accept),
      .load_addr  (cmd_addr),
      .advance    (advance),
      .addr       (HADDR),
      .next_cross (next_cross)
   );

   always_ff @(posedge HCLK or negedge HRESET) begin
      if (!HRESET) begin
         state     <= ST_IDLE;
         HTRANS    <= HTRANS_IDLE;
         HWRITE    <= 1'b0;
         HBURST    <= HBURST_SINGLE;
         HWDATA    <= '0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         addr_left <= '0;
         data_left <= '0;
         dphase    <= 1'b0;
         err_flag  <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;

         // An accepted address phase becomes the next data phase.
         if (HREADY)
            dphase <= addr_acc;
         if (wr_ready)
            HWDATA <= wr_data;
         if (data_done) begin
            data_left <= data_left - LEN_W'(1);
            if (!HWRITE && !err_flag) begin
               rd_data  <= HRDATA;
               rd_valid <= 1'b1;
            end
         end

         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  state     <= ST_ADDR;
                  HTRANS    <= HTRANS_NONSEQ;
                  HWRITE    <= cmd_write;
                  HBURST    <= (len_n == LEN_W'(1)) ? HBURST_SINGLE : HBURST_INCR;
                  addr_left <= len_n;
                  data_left <= len_n;
                  err_flag  <= 1'b0;
               end
            end
            ST_ADDR: begin
               if (err_hit) begin
                  // Cancel the pending address phase; only the errored data phase remains.
                  HTRANS   <= HTRANS_IDLE;
                  state    <= ST_LAST;
                  err_flag <= 1'b1;
               end else if (addr_acc) begin
                  addr_left <= addr_left - LEN_W'(1);
                  if (addr_left == LEN_W'(1)) begin
                     HTRANS <= HTRANS_IDLE;
                     state  <= ST_LAST;
                  end else begin
                     HTRANS <= next_cross ? HTRANS_NONSEQ : HTRANS_SEQ;
                  end
               end
            end
            ST_LAST: begin
               if (err_hit)
                  err_flag <= 1'b1;
               if (last_data) begin
                  state <= ST_IDLE;
                  done  <= 1'b1;
                  err   <= err_flag | err_hit;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
